// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// funct3 size/sign codes, FSM states and lane geometry.
package lsu_pkg;

  localparam int LANE_W = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_RESP
  } lsu_state_e;

  function automatic logic f3_legal(
    input logic       we,
    input logic [2:0] f3
  );
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane extraction with sign/zero extension,
// plus sub-word merge of store data into a read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [4:0]  sh_b;
  logic [4:0]  sh_h;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane 0 is the most significant byte.
  assign sh_b = {~lane, 3'b000};
  assign sh_h = {~lane[1], 4'b0000};

  assign byte_v = 8'(word >> sh_b);
  assign half_v = 16'(word >> sh_h);

  always_comb begin
    load_val = '0;
    case (funct3)
      F3_B:  load_val = {{24{byte_v[7]}}, byte_v};
      F3_H:  load_val = {{16{half_v[15]}}, half_v};
      F3_W:  load_val = word;
      F3_BU: load_val = {24'h0, byte_v};
      F3_HU: load_val = {16'h0, half_v};
      default: load_val = '0;
    endcase
  end

  always_comb begin
    store_word = wdata;
    case (funct3)
      F3_B: store_word =
        (word & ~(32'h0000_00ff << sh_b)) |
        (32'(wdata[LANE_W-1:0]) << sh_b);
      F3_H: store_word =
        (word & ~(32'h0000_ffff << sh_h)) |
        (32'(wdata[15:0]) << sh_h);
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit in front of a word-wide,
// big-endian data memory; sub-word stores use read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_BUS_WIDTH = 32,
  parameter int MEM_DEPTH      = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [2:0]                req_funct3,
  input  logic [ADDR_BUS_WIDTH-1:0] req_addr,
  input  logic [DATA_BUS_WIDTH-1:0] req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_BUS_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_fault,
  output logic [ADDR_BUS_WIDTH-1:0] mem_addr,
  output logic [DATA_BUS_WIDTH-1:0] mem_write_data,
  output logic                      mem_write_en,
  input  logic [DATA_BUS_WIDTH-1:0] mem_read_data
);

  lsu_state_e                state_q, state_d;
  logic                      we_q, we_d;
  logic [2:0]                f3_q, f3_d;
  logic [ADDR_BUS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_BUS_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_BUS_WIDTH-1:0] rdata_q, rdata_d;
  logic                      fault_q, fault_d;

  logic        acc_half;
  logic        acc_word;
  logic        acc_fault;
  logic [31:0] load_val;
  logic [31:0] store_word;

  lsu_lane_align u_align (
    .word       (mem_read_data),
    .lane       (addr_q[1:0]),
    .funct3     (f3_q),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  assign acc_half = (req_funct3[1:0] == 2'b01);
  assign acc_word = (req_funct3 == F3_W);

  assign acc_fault =
    ~f3_legal(req_we, req_funct3) |
    (acc_half & req_addr[0]) |
    (acc_word & |req_addr[1:0]) |
    (req_addr >= ADDR_BUS_WIDTH'(MEM_DEPTH));

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          fault_d = acc_fault;
          if (acc_fault) begin
            state_d = S_RESP;
          end else if (req_we & acc_word) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (we_q) begin
          wdata_d = store_word;
          state_d = S_WRITE;
        end else begin
          rdata_d = load_val;
          state_d = S_RESP;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign req_ready    = (state_q == S_IDLE) & rst_n;
  assign rsp_valid    = (state_q == S_RESP) & rst_n;
  assign mem_write_en = (state_q == S_WRITE) & rst_n;

  assign mem_addr = (state_q == S_IDLE) ? '0 :
                    {addr_q[ADDR_BUS_WIDTH-1:2], 2'b00};

  assign mem_write_data = wdata_q;
  assign rsp_rdata      = rdata_q;
  assign rsp_fault      = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory model with
// cycle-accurate expectations plus directed literal checks.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_write_en;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  load_store_unit #(
    .ADDR_BUS_WIDTH (32),
    .DATA_BUS_WIDTH (32),
    .MEM_DEPTH      (64)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_fault      (rsp_fault),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read_data  (mem_read_data)
  );

  // data_memory stand-in: combinational read, negedge write
  logic [31:0] mem [16];
  int          n_writes = 0;

  assign mem_read_data = mem[mem_addr[5:2]];

  always @(negedge clk) begin
    if (mem_write_en) begin
      mem[mem_addr[5:2]] = mem_write_data;
      n_writes = n_writes + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out", nm);
  endtask

  // reference model: byte-addressed, lower address = MSB
  logic [7:0] rb [64];
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rword(input int a);
    return {rb[a], rb[a+1], rb[a+2], rb[a+3]};
  endfunction

  bit          pend = 0;
  int          p_acc, p_resp, p_wr;
  int          next_free = 0;
  logic        p_we;
  logic [2:0]  p_f3;
  logic [31:0] p_addr, p_wdata, p_rdata;
  logic        p_fault;

  always @(negedge clk) begin : model
    bit          rdy_e, rv_e, we_e, legal, flt;
    logic [31:0] ma_e, v;
    logic [15:0] h;
    int          a, sz;
    if (cyc >= 1) begin
      rdy_e = rst_n && (cyc >= next_free);
      rv_e  = pend && (cyc == p_resp) && rst_n;
      we_e  = pend && (cyc == p_wr) && rst_n;
      ma_e  = (pend && cyc > p_acc) ?
              {p_addr[31:2], 2'b00} : 32'h0;
      chk("req_ready", {31'h0, req_ready}, {31'h0, rdy_e});
      chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, rv_e});
      chk("mem_write_en", {31'h0, mem_write_en},
          {31'h0, we_e});
      chk("mem_addr", mem_addr, ma_e);
      if (rv_e) begin
        chk("rsp_rdata", rsp_rdata, p_rdata);
        chk("rsp_fault", {31'h0, rsp_fault}, {31'h0, p_fault});
      end
      if (we_e) begin
        a = int'(p_addr[5:0]);
        case (p_f3)
          3'd0: rb[a] = p_wdata[7:0];
          3'd1: begin
            rb[a]   = p_wdata[15:8];
            rb[a+1] = p_wdata[7:0];
          end
          default: begin
            rb[a]   = p_wdata[31:24];
            rb[a+1] = p_wdata[23:16];
            rb[a+2] = p_wdata[15:8];
            rb[a+3] = p_wdata[7:0];
          end
        endcase
        chk("mem_write_data", mem_write_data,
            rword(int'({p_addr[5:2], 2'b00})));
      end
      if (pend && cyc == p_resp) pend = 0;
      if (!rst_n) begin
        pend = 0;
        next_free = cyc + 1;
      end else if (req_valid && rdy_e) begin
        p_acc   = cyc;
        p_we    = req_we;
        p_f3    = req_funct3;
        p_addr  = req_addr;
        p_wdata = req_wdata;
        p_rdata = 32'h0;
        p_wr    = -1;
        sz      = int'(req_funct3) % 4;
        if (req_we) legal = req_funct3 <= 3'd2;
        else legal = req_funct3 inside {0, 1, 2, 4, 5};
        flt = !legal ||
              (sz == 1 && req_addr % 2 != 0) ||
              (sz == 2 && req_addr % 4 != 0) ||
              (req_addr >= 32'd64);
        p_fault = flt;
        if (flt) begin
          p_resp = cyc + 1;
        end else if (!req_we) begin
          a = int'(req_addr[5:0]);
          if (sz == 0) begin
            v = req_funct3[2] ? {24'h0, rb[a]} :
                {{24{rb[a][7]}}, rb[a]};
          end else if (sz == 1) begin
            h = {rb[a], rb[a+1]};
            v = req_funct3[2] ? {16'h0, h} : {{16{h[15]}}, h};
          end else begin
            v = rword(a);
          end
          p_rdata = v;
          p_resp  = cyc + 2;
        end else if (sz == 2) begin
          p_wr   = cyc + 1;
          p_resp = cyc + 2;
        end else begin
          p_wr   = cyc + 2;
          p_resp = cyc + 3;
        end
        next_free = p_resp + 1;
        pend = 1;
      end
    end
  end

  task automatic req(input logic        we,
                     input logic [2:0]  f3,
                     input logic [31:0] a,
                     input logic [31:0] wd,
                     input bit          lit,
                     input logic [31:0] exp_rd,
                     input logic        exp_f,
                     input int          exp_lat,
                     input int          exp_wr);
    bit got;
    int lat, wr0;
    @(posedge clk); #1;
    req_we = we;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    req_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1;
        break;
      end
    end
    wr0 = n_writes;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!got) begin
      timeout("accept");
      return;
    end
    got = 0;
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      timeout("response");
    end else if (lit) begin
      chk("lit_latency", 32'(lat), 32'(exp_lat));
      chk("lit_rdata", rsp_rdata, exp_rd);
      chk("lit_fault", {31'h0, rsp_fault}, {31'h0, exp_f});
      chk("lit_writes", 32'(n_writes - wr0), 32'(exp_wr));
    end
  endtask

  initial begin
    int acc, rsp, wr0;
    bit flip;
    logic [31:0] w, ra;
    logic [2:0]  rf;
    logic        rw;
    for (int i = 0; i < 16; i++) begin
      w = (i == 0) ? 32'h0000_000a : $urandom;
      mem[i] = w;
      rb[4*i]   = w[31:24];
      rb[4*i+1] = w[23:16];
      rb[4*i+2] = w[15:8];
      rb[4*i+3] = w[7:0];
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_fault", {31'h0, rsp_fault}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);

    req(0, 3'd2, 0, 0, 1, 32'h0000_000a, 0, 2, 0);
    req(1, 3'd2, 4, 32'h80ff_1234, 1, 0, 0, 2, 1);
    req(0, 3'd0, 4, 0, 1, 32'hffff_ff80, 0, 2, 0);
    req(0, 3'd4, 5, 0, 1, 32'h0000_00ff, 0, 2, 0);
    req(0, 3'd1, 6, 0, 1, 32'h0000_1234, 0, 2, 0);
    req(0, 3'd5, 4, 0, 1, 32'h0000_80ff, 0, 2, 0);
    req(1, 3'd0, 7, 32'h0000_00ab, 1, 0, 0, 3, 1);
    req(0, 3'd2, 4, 0, 1, 32'h80ff_12ab, 0, 2, 0);
    req(0, 3'd1, 5, 0, 1, 0, 1, 1, 0);
    req(1, 3'd2, 6, 32'h1111_2222, 1, 0, 1, 1, 0);
    req(0, 3'd2, 64, 0, 1, 0, 1, 1, 0);
    req(0, 3'd3, 0, 0, 1, 0, 1, 1, 0);

    // reset lands on the WRITE cycle of an sh
    @(posedge clk); #1;
    req_we = 1'b1;
    req_funct3 = 3'd1;
    req_addr = 32'd4;
    req_wdata = 32'h0000_5555;
    req_valid = 1'b1;
    @(negedge clk);
    chk("sh_accept", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    wr0 = n_writes;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_writes", 32'(n_writes - wr0), 32'h0);
    chk("mid_rst_valid", {31'h0, rsp_valid}, 32'h0);
    chk("mid_rst_rdata", rsp_rdata, 32'h0);
    chk("mid_rst_fault", {31'h0, rsp_fault}, 32'h0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_wdata", mem_write_data, 32'h0);
    chk("mid_rst_we", {31'h0, mem_write_en}, 32'h0);
    rsp = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) rsp++;
    end
    chk("mid_rst_no_rsp", 32'(rsp), 32'h0);
    req(0, 3'd2, 4, 0, 1, 32'h80ff_12ab, 0, 2, 0);

    // back-to-back: valid held for 10 cycles
    acc = 0;
    rsp = 0;
    @(posedge clk); #1;
    req_we = 1'b0;
    req_funct3 = 3'd2;
    req_addr = 32'd0;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      flip = 0;
      @(negedge clk);
      if (req_ready) begin
        acc++;
        flip = 1;
      end
      if (rsp_valid) rsp++;
      @(posedge clk); #1;
      if (flip) req_addr = req_addr ^ 32'd4;
      if (i == 9) req_valid = 1'b0;
    end
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) rsp++;
    end
    chk("burst_accepts", 32'(acc), 32'd4);
    chk("burst_responses", 32'(rsp), 32'd4);

    repeat (150) begin
      rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) begin
        if (rw) rf = 3'($urandom_range(0, 2));
        else begin
          rf = 3'($urandom_range(0, 4));
          if (rf == 3'd3) rf = 3'd5;
        end
      end else begin
        rf = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 9) == 0) ra = $urandom_range(64, 200);
      else ra = $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      req(rw, rf, ra, $urandom, 0, 0, 0, 0, 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the single-cycle core's execute stage and `data_memory`. It takes one memory request at a time over a valid/ready handshake and aligns the address to a word. It performs byte/halfword/word loads with sign or zero extension, and performs sub-word stores as a read-modify-write on the word-wide, big-endian data memory. It returns a one-cycle response with data or a fault flag.

## Interface
- `ADDR_BUS_WIDTH`, 32, request and memory address width
- `DATA_BUS_WIDTH`, 32, data width; fixed at 32 (four 8-bit lanes)
- `MEM_DEPTH`, 64, data-memory size in bytes; used for range check

- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32I size/sign code
- `req_addr`  in  ADDR_BUS_WIDTH  byte address
- `req_wdata`  in  DATA_BUS_WIDTH  store data; the low bytes are used for sub-word stores
- `rsp_valid`  out  1  response strobe, one cycle
- `rsp_rdata`  out  DATA_BUS_WIDTH  load result; 0 for stores and faults
- `rsp_fault`  out  1  request rejected (misaligned, out-of-range or illegal code)
- `mem_addr`  out  ADDR_BUS_WIDTH  word-aligned address to `data_memory`
- `mem_write_data`  out  DATA_BUS_WIDTH  word to write
- `mem_write_en`  out  1  write strobe; memory commits on the falling edge of the same cycle
- `mem_read_data`  in  DATA_BUS_WIDTH  combinational read word, big-endian

## Operation
- States: IDLE, LOAD, WRITE, RESP.
- `req_ready` = 1 only in IDLE with `rst_n` high.
- A request is accepted when `req_valid & req_ready`. On acceptance the unit registers `we`, `funct3`, `addr` and `wdata`.
- Lane: `k = addr[1:0]`. Byte lane k is `mem_read_data[31-8k -: 8]`. Halfword at k (k ∈ {0,2}) is `[31-8k -: 16]`.
- `mem_addr = {addr[31:2], 2'b00}` in every state except IDLE; 0 in IDLE.
- Load codes: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Store codes: 000 sb, 001 sh, 010 sw. Any other code is illegal.
- Fault checks, evaluated at acceptance:
  - illegal code;
  - halfword with `addr[0]`=1;
  - word with `addr[1:0]`≠0;
  - `addr >= MEM_DEPTH`.
- On a fault: IDLE → RESP directly with `rsp_fault`=1 and `rsp_rdata`=0. Memory is never written.
- Transitions:
  - Load: IDLE → LOAD → RESP. In LOAD the extracted lane is sign- or zero-extended into `rsp_rdata`.
  - sw: IDLE → WRITE → RESP. `mem_write_data = wdata`.
  - sb/sh: IDLE → LOAD → WRITE → RESP. In LOAD the merged word is captured: the read word with lane k replaced by `wdata[7:0]` or `wdata[15:0]`.
  - WRITE: `mem_write_en` = 1 for exactly that cycle.
  - RESP: `rsp_valid` = 1, `rsp_rdata`/`rsp_fault` valid. Next state is IDLE.
- `req_valid` during non-IDLE states is ignored, not queued. The request is accepted once it is seen with ready high.

## Timing
- Reset values: state IDLE; `rsp_valid`, `rsp_rdata`, `rsp_fault`, `mem_addr`, `mem_write_data` = 0.
- `mem_write_en = (state==WRITE) & rst_n`. No memory write occurs in any cycle where `rst_n` is low, including a reset that lands mid-WRITE.
- Reset mid-operation: at the next edge the unit discards the request, returns to IDLE and produces no response.
- Latency from the acceptance edge to `rsp_valid`:
  - 2 cycles for loads and sw;
  - 3 cycles for sb/sh;
  - 1 cycle for faults.
- Throughput: a new request is accepted in the cycle after RESP, so one request per 3/4 cycles.
- Read data is sampled at the rising edge ending LOAD. The preceding falling-edge write comes only from this unit, so no hazard exists.

## Structure
- Package `lsu_pkg`:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - state enum;
  - lane width 8.
- Sub-module `lsu_lane_align` (combinational):
  - inputs: word, lane, funct3, wdata;
  - outputs: extended load value and merged store word.
- The FSM and registers live in `load_store_unit`.

## Test plan
- After reset, with memory word 0 = 0x0000000A: lw addr 0 → `rsp_rdata` 0x0000000A, `rsp_fault` 0, `rsp_valid` 2 cycles after acceptance, `mem_write_en` never high.
- sw 0x80FF1234 @4, then the following loads:
  - lb @4 → 0xFFFFFF80;
  - lbu @5 → 0x000000FF;
  - lh @6 → 0x00001234;
  - lhu @4 → 0x000080FF.
- sb 0x000000AB @7 → response 3 cycles after acceptance, `mem_write_en` high exactly one cycle. Then lw @4 → 0x80FF12AB.
- The following requests each give `rsp_fault` 1 one cycle after acceptance, with zero memory writes:
  - lh @5;
  - sw @6;
  - lw @64;
  - funct3 011.
- Assert `rst_n` low during the WRITE cycle of sh 0x5555 @4 → no write, no response, all outputs 0. lw @4 afterwards returns the old word.
- Hold `req_valid` high for 10 cycles with alternating lw @0 / lw @4 → requests accepted only in IDLE cycles, one `rsp_valid` per accept, data correct, no request lost or duplicated.
